cgra_tile_cfg_seq: RTL and testbench

//  Per-tile configuration store and sequencer, one instance per CGRA tile.
//  - Load side: accepts the CSR loader's broadcast writes (tile addr/data/wr_en/valid/ready) into a KernelSize-deep config memory.
//  - Run side: replays the stored words cyclically, one slot per enabled step, driving the tile datapath's control.

---
 rtl/cgra_tile_cfg_seq.sv | 155 +++++++++++++++
 tb/tb_cgra_tile_cfg_seq.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cgra_tile_cfg_seq.sv
`default_nettype none
// ============================================================================
// Module      : cgra_tile_cfg_seq
// Description : Per-tile configuration store and sequencer. Captures the CSR
//               loader's broadcast writes into a KernelSize-deep config memory
//               and, once started, replays slots 0..ii-1 cyclically, one slot
//               per enabled step, to drive the tile datapath control.
// Revision    : 1.0 - initial release
// ============================================================================
module cgra_tile_cfg_seq #(
  parameter int KernelSize = 4,
  parameter int CfgWidth   = 49,
  parameter int AddrWidth  = $clog2(KernelSize),
  parameter int IterWidth  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [AddrWidth-1:0] cfg_addr_i,
  input  logic [CfgWidth-1:0]  cfg_data_i,
  input  logic                 cfg_wr_en_i,
  input  logic                 cfg_wr_valid_i,
  output logic                 cfg_ready_o,
  input  logic [AddrWidth:0]   ii_i,
  input  logic                 run_start_i,
  input  logic                 run_stop_i,
  input  logic                 step_en_i,
  input  logic                 err_clr_i,
  output logic [CfgWidth-1:0]  cfg_o,
  output logic                 cfg_valid_o,
  output logic [AddrWidth-1:0] slot_o,
  output logic                 running_o,
  output logic                 loaded_o,
  output logic [IterWidth-1:0] iter_count_o,
  output logic                 cfg_err_o
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [AddrWidth:0] c_ii_max = (AddrWidth+1)'(KernelSize);
  localparam logic [AddrWidth:0] c_ii_one = (AddrWidth+1)'(1);

  state_t                r_state, w_state_d;
  logic [CfgWidth-1:0]   r_mem [KernelSize];
  logic [KernelSize-1:0] r_mask, w_mask_d;
  logic [AddrWidth:0]    r_ii, w_ii_d;
  logic [AddrWidth-1:0]  r_slot, w_slot_d, w_slot_nxt;
  logic [CfgWidth-1:0]   r_cfg, w_cfg_d, w_start_cfg;
  logic                  r_cfg_valid, w_cfg_valid_d;
  logic [IterWidth-1:0]  r_iter, w_iter_d, w_iter_inc;
  logic                  r_loaded;
  logic                  r_err, w_err_set;
  logic                  w_addr_ok, w_wr_acc, w_ii_legal, w_wrap;

  // Write handshake and the small arithmetic shared by the FSM
  assign cfg_ready_o = (r_state == S_IDLE);
  assign w_addr_ok   = (32'(cfg_addr_i) < 32'(KernelSize));
  assign w_wr_acc    = cfg_wr_valid_i & cfg_wr_en_i & cfg_ready_o & w_addr_ok;
  assign w_ii_legal  = (ii_i != '0) && (ii_i <= c_ii_max);
  assign w_wrap      = ({1'b0, r_slot} == (r_ii - c_ii_one));
  assign w_slot_nxt  = w_wrap ? '0 : r_slot + 1'b1;
  assign w_iter_inc  = (r_iter == '1) ? r_iter : r_iter + 1'b1;
  // A slot-0 write landing on the start edge must be seen by the first replay
  assign w_start_cfg = (w_wr_acc && (cfg_addr_i == '0)) ? cfg_data_i : r_mem[0];
  assign w_err_set   = (r_state == S_IDLE) && run_start_i && !w_ii_legal;

  // Written-slot mask including the write accepted this cycle
  always_comb begin
    w_mask_d = r_mask;
    if (w_wr_acc) w_mask_d[cfg_addr_i] = 1'b1;
  end

  // Next-state and next-output logic for the IDLE/RUN sequencer
  always_comb begin
    w_state_d     = r_state;
    w_ii_d        = r_ii;
    w_slot_d      = r_slot;
    w_cfg_d       = r_cfg;
    w_cfg_valid_d = r_cfg_valid;
    w_iter_d      = r_iter;
    case (r_state)
      S_IDLE: begin
        if (run_start_i && w_ii_legal) begin
          w_state_d     = S_RUN;
          w_ii_d        = ii_i;
          w_slot_d      = '0;
          w_cfg_d       = w_start_cfg;
          w_cfg_valid_d = 1'b1;
          w_iter_d      = '0;
        end
      end
      S_RUN: begin
        if (run_stop_i) begin
          w_state_d     = S_IDLE;
          w_cfg_valid_d = 1'b0;
          w_cfg_d       = '0;
          w_slot_d      = '0;
        end else if (step_en_i) begin
          w_slot_d = w_slot_nxt;
          w_cfg_d  = r_mem[w_slot_nxt];
          if (w_wrap) w_iter_d = w_iter_inc;
        end
      end
      default: w_state_d = S_IDLE;
    endcase
  end

  // Sequencer state register and its registered outputs
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state     <= S_IDLE;
      r_ii        <= '0;
      r_slot      <= '0;
      r_cfg       <= '0;
      r_cfg_valid <= 1'b0;
      r_iter      <= '0;
      r_loaded    <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_ii        <= w_ii_d;
      r_slot      <= w_slot_d;
      r_cfg       <= w_cfg_d;
      r_cfg_valid <= w_cfg_valid_d;
      r_iter      <= w_iter_d;
      r_loaded    <= &w_mask_d;
      // A new error beats a simultaneous clear
      if (w_err_set)      r_err <= 1'b1;
      else if (err_clr_i) r_err <= 1'b0;
    end
  end

  // Config memory and written-slot mask
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < KernelSize; i++) r_mem[i] <= '0;
      r_mask <= '0;
    end else begin
      if (w_wr_acc) r_mem[cfg_addr_i] <= cfg_data_i;
      r_mask <= w_mask_d;
    end
  end

  assign cfg_o        = r_cfg;
  assign cfg_valid_o  = r_cfg_valid;
  assign slot_o       = r_slot;
  assign running_o    = (r_state == S_RUN);
  assign loaded_o     = r_loaded;
  assign iter_count_o = r_iter;
  assign cfg_err_o    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_cgra_tile_cfg_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_cgra_tile_cfg_seq
// Description : Directed bench for cgra_tile_cfg_seq. Stimulus pushes the
//               expected replay word/slot/iteration into a queue; a monitor
//               pops and compares on every cycle cfg_valid_o is high.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cgra_tile_cfg_seq;
  localparam int KS = 4;
  localparam int CW = 49;
  localparam int AW = 2;
  localparam int IW = 16;

  logic          clk;
  logic          rst_ni;
  logic [AW-1:0] cfg_addr;
  logic [CW-1:0] cfg_data;
  logic          cfg_wr_en, cfg_wr_valid, cfg_ready;
  logic [AW:0]   ii;
  logic          run_start, run_stop, step_en, err_clr;
  logic [CW-1:0] cfg;
  logic          cfg_valid;
  logic [AW-1:0] slot;
  logic          running, loaded, cfg_err;
  logic [IW-1:0] iter_count;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [CW-1:0] cfg;
    logic [AW-1:0] slot;
    logic [IW-1:0] iter;
  } exp_t;

  exp_t sb_q[$];
  exp_t m_exp;

  cgra_tile_cfg_seq #(
    .KernelSize(KS), .CfgWidth(CW), .AddrWidth(AW), .IterWidth(IW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .cfg_addr_i(cfg_addr), .cfg_data_i(cfg_data),
    .cfg_wr_en_i(cfg_wr_en), .cfg_wr_valid_i(cfg_wr_valid),
    .cfg_ready_o(cfg_ready),
    .ii_i(ii), .run_start_i(run_start), .run_stop_i(run_stop),
    .step_en_i(step_en), .err_clr_i(err_clr),
    .cfg_o(cfg), .cfg_valid_o(cfg_valid), .slot_o(slot),
    .running_o(running), .loaded_o(loaded),
    .iter_count_o(iter_count), .cfg_err_o(cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input logic [CW-1:0] c, input logic [AW-1:0] s,
                      input logic [IW-1:0] it);
    exp_t e;
    e.cfg  = c;
    e.slot = s;
    e.iter = it;
    sb_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Replay-stream monitor
  always @(negedge clk) begin
    if (cfg_valid === 1'b1) begin
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL stream: unexpected cfg=%0h slot=%0d iter=%0d, nothing expected",
                 cfg, slot, iter_count);
      end else begin
        m_exp = sb_q.pop_front();
        if ({cfg, slot, iter_count} !== m_exp) begin
          n_fail++;
          $display("FAIL stream: got cfg=%0h slot=%0d iter=%0d expected cfg=%0h slot=%0d iter=%0d",
                   cfg, slot, iter_count, m_exp.cfg, m_exp.slot, m_exp.iter);
        end
      end
    end
  end

  initial begin
    rst_ni = 1'b0; cfg_addr = '0; cfg_data = '0; cfg_wr_en = 1'b0;
    cfg_wr_valid = 1'b0; ii = '0; run_start = 1'b0; run_stop = 1'b0;
    step_en = 1'b0; err_clr = 1'b0;
    cyc(); cyc();
    @(negedge clk);
    chk("rst_cfg", 64'(cfg), 0);
    chk("rst_valid", 64'(cfg_valid), 0);
    chk("rst_slot", 64'(slot), 0);
    chk("rst_running", 64'(running), 0);
    chk("rst_loaded", 64'(loaded), 0);
    chk("rst_iter", 64'(iter_count), 0);
    chk("rst_err", 64'(cfg_err), 0);
    chk("rst_ready", 64'(cfg_ready), 1);
    cyc();
    rst_ni = 1'b1;

    // Load slots 0..3 with 1..4
    for (int i = 0; i < KS; i++) begin
      cfg_addr = AW'(i); cfg_data = CW'(i + 1);
      cfg_wr_en = 1'b1; cfg_wr_valid = 1'b1;
      @(negedge clk);
      chk("load_ready", 64'(cfg_ready), 1);
      chk("load_loaded_pre", 64'(loaded), 0);
      cyc();
    end
    // valid without wr_en must not write
    cfg_wr_en = 1'b0; cfg_addr = 2'd2; cfg_data = CW'('hFF);
    @(negedge clk);
    chk("loaded_post", 64'(loaded), 1);
    cyc();
    cfg_wr_valid = 1'b0;

    // ii=4, nine steps
    ii = 3'd4; run_start = 1'b1;
    push(1, 0, 0);
    cyc();
    run_start = 1'b0; step_en = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      push(CW'((k % 4) + 1), AW'(k % 4), IW'(k / 4));
      cyc();
    end
    run_stop = 1'b1;
    cyc();
    run_stop = 1'b0; step_en = 1'b0;
    @(negedge clk);
    chk("stop_valid", 64'(cfg_valid), 0);
    chk("stop_running", 64'(running), 0);
    chk("stop_cfg", 64'(cfg), 0);
    chk("stop_iter_hold", 64'(iter_count), 2);
    cyc();

    // ii=2 with a stall
    ii = 3'd2; run_start = 1'b1;
    push(1, 0, 0);
    cyc();
    run_start = 1'b0; step_en = 1'b1; push(2, 1, 0); cyc();
    step_en = 1'b0; push(2, 1, 0); cyc();
    step_en = 1'b1; push(1, 0, 1); cyc();
    // Write attempt while running
    step_en = 1'b0; cfg_wr_valid = 1'b1; cfg_wr_en = 1'b1;
    cfg_addr = 2'd1; cfg_data = CW'('h55);
    push(1, 0, 1);
    @(negedge clk);
    chk("run_ready", 64'(cfg_ready), 0);
    cyc();
    cfg_wr_valid = 1'b0; cfg_wr_en = 1'b0;
    run_stop = 1'b1; step_en = 1'b1;
    cyc();
    run_stop = 1'b0; step_en = 1'b0;
    @(negedge clk);
    chk("stop2_valid", 64'(cfg_valid), 0);
    chk("stop2_running", 64'(running), 0);
    cyc();
    // Slot 1 must still hold 2
    run_start = 1'b1; push(1, 0, 0); cyc();
    run_start = 1'b0; step_en = 1'b1; push(2, 1, 0); cyc();
    run_stop = 1'b1;
    cyc();
    run_stop = 1'b0; step_en = 1'b0;

    // Illegal ii values and error clear
    ii = 3'd0; run_start = 1'b1;
    cyc();
    run_start = 1'b0;
    @(negedge clk);
    chk("err_ii0", 64'(cfg_err), 1);
    chk("err_ii0_idle", 64'(running), 0);
    cyc();
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    @(negedge clk);
    chk("err_clr", 64'(cfg_err), 0);
    cyc();
    ii = 3'd5; run_start = 1'b1; err_clr = 1'b1;
    cyc();
    run_start = 1'b0; err_clr = 1'b0;
    @(negedge clk);
    chk("err_ii5_set_wins", 64'(cfg_err), 1);
    chk("err_ii5_idle", 64'(running), 0);
    cyc();
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;

    // Same-edge slot-0 write and start, then reset mid-run
    cfg_wr_valid = 1'b1; cfg_wr_en = 1'b1; cfg_addr = 2'd0;
    cfg_data = CW'('hAA); ii = 3'd4; run_start = 1'b1;
    push(CW'('hAA), 0, 0);
    cyc();
    cfg_wr_valid = 1'b0; cfg_wr_en = 1'b0; run_start = 1'b0;
    step_en = 1'b1; push(2, 1, 0);
    cyc();
    step_en = 1'b0; rst_ni = 1'b0;
    cyc();
    @(negedge clk);
    chk("mid_rst_cfg", 64'(cfg), 0);
    chk("mid_rst_valid", 64'(cfg_valid), 0);
    chk("mid_rst_running", 64'(running), 0);
    chk("mid_rst_loaded", 64'(loaded), 0);
    chk("mid_rst_slot", 64'(slot), 0);
    chk("mid_rst_iter", 64'(iter_count), 0);
    cyc();
    rst_ni = 1'b1;

    // ii=1 on an unwritten memory: slot stays 0, each step is one pass
    ii = 3'd1; run_start = 1'b1; push(0, 0, 0); cyc();
    run_start = 1'b0; step_en = 1'b1; push(0, 0, 1); cyc();
    push(0, 0, 2); cyc();
    step_en = 1'b0; run_stop = 1'b1;
    cyc();
    run_stop = 1'b0;
    @(negedge clk);
    chk("ii1_iter", 64'(iter_count), 2);
    chk("ii1_stopped", 64'(running), 0);
    cyc(); cyc();
    chk("sb_drained", 64'(sb_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
